reg_file_2r1w: RTL
==================

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, meaning the register count; it SHALL be fixed at 32 to match the 5-bit addresses.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: write-back enable.
REQ-006 The block SHALL have port wr_addr, input, 5 bits: destination register (rt or rd as selected upstream).
REQ-007 The block SHALL have port wr_data, input, DATA_W bits: write-back value.
REQ-008 The block SHALL have port rd_addr1, input, 5 bits: read port 1 address (rs).
REQ-009 The block SHALL have port rd_addr2, input, 5 bits: read port 2 address (rt).
REQ-010 The block SHALL have port rd_data1, output, DATA_W bits: read port 1 data.
REQ-011 The block SHALL have port rd_data2, output, DATA_W bits: read port 2 data.
REQ-012 The block SHALL have port dbg_addr, input, 5 bits: debug read address.
REQ-013 The block SHALL have port dbg_data, output, DATA_W bits: debug read data, with no bypass applied.
REQ-014 The block SHALL have port wr_count, output, 16 bits: count of committed writes.

Function
REQ-015 Storage SHALL be 32 registers of DATA_W bits each; register 0 SHALL always read as 0.
REQ-016 A write SHALL commit on the rising clk edge when wr_en=1 and wr_addr!=0; the result SHALL be visible in storage from the next cycle on.
REQ-017 A write with wr_addr=0 SHALL be discarded: storage stays unchanged and wr_count does not increment.
REQ-018 Reads SHALL be combinational: rd_dataN reflects rd_addrN in the same cycle, with zero latency.
REQ-019 Write-through bypass SHALL apply: if wr_en=1, wr_addr!=0 and rd_addrN==wr_addr, then rd_dataN SHALL equal wr_data in that same cycle.
REQ-020 Both read ports SHALL bypass independently; rd_addr1==rd_addr2==wr_addr SHALL drive wr_data on both ports.
REQ-021 A read of address 0 SHALL return 0 even when wr_en=1 and wr_addr=0 with nonzero wr_data.
REQ-022 dbg_data SHALL return the stored value only, without the bypass; dbg_addr=0 SHALL return 0.
REQ-023 wr_count SHALL increment by 1 per committed write and SHALL wrap from 0xFFFF to 0x0000.
REQ-024 Back-to-back writes to the same address on consecutive cycles SHALL leave the last value in storage.
REQ-025 X or don't-care values on wr_addr or wr_data while wr_en=0 SHALL NOT alter state.

Reset
REQ-026 When rst_n=0, all 32 registers and wr_count SHALL clear to 0 immediately, independent of clk.
REQ-027 While rst_n=0, rd_data1, rd_data2 and dbg_data SHALL read 0, except that rd_dataN SHALL show bypassed wr_data while wr_en=1 and the address matches (combinational path).
REQ-028 A write whose clock edge occurs while rst_n=0 SHALL be discarded.
REQ-029 Deassertion of rst_n SHALL be sampled by clk-synchronous logic; the first write SHALL commit on the first rising edge after rst_n=1.
REQ-030 Reset asserted mid-operation SHALL discard all prior contents, with no partial retention.

Verification
REQ-031 Scenario, reset: rst_n=0 pulse between edges -> all dbg reads 0..31 return 0 and wr_count=0.
REQ-032 Scenario, write then read: write 0xDEADBEEF to r8, next cycle rd_addr1=8 -> rd_data1=0xDEADBEEF and wr_count=1.
REQ-033 Scenario, bypass: wr_en=1, wr_addr=9, wr_data=0x12345678 with rd_addr1=rd_addr2=9 in the same cycle -> both ports read 0x12345678, while dbg_addr=9 reads the old value 0.
REQ-034 Scenario, r0 protection: write 0xFFFFFFFF to r0 -> rd_data1 with rd_addr1=0 reads 0 in the same cycle and the next cycle, and wr_count is unchanged.
REQ-035 Scenario, counter wrap: 65536 committed writes -> wr_count returns to 0x0000.
REQ-036 Scenario, reset mid-stream: write r5=0xA5, then assert rst_n=0 asynchronously between edges -> rd_data1 with rd_addr1=5 drops to 0 before the next edge.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with write-through bypass, an
// unbypassed debug read port and a committed-write counter.
module reg_file_2r1w #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd_addr1,
  input  logic [4:0]        rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  localparam int unsigned CNT_W = 16;

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_commit_c;

  // A write only takes effect when enabled and not aimed at the hardwired zero register.
  always_comb begin
    wr_commit_c = 1'b0;
    if (wr_en && (wr_addr != 5'd0)) begin
      wr_commit_c = 1'b1;
    end
  end

  // Storage array; reset clears every entry so reads during reset return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit_c) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Committed-write counter; wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (wr_commit_c) begin
      wr_count <= wr_count + CNT_W'(1);
    end
  end

  // Read port 1: zero register, then same-cycle bypass, then storage.
  always_comb begin
    rd_data1 = '0;
    if (rd_addr1 == 5'd0) begin
      rd_data1 = '0;
    end else if (wr_commit_c && (rd_addr1 == wr_addr)) begin
      rd_data1 = wr_data;
    end else begin
      rd_data1 = regs[rd_addr1];
    end
  end

  // Read port 2: same priority as port 1, evaluated independently.
  always_comb begin
    rd_data2 = '0;
    if (rd_addr2 == 5'd0) begin
      rd_data2 = '0;
    end else if (wr_commit_c && (rd_addr2 == wr_addr)) begin
      rd_data2 = wr_data;
    end else begin
      rd_data2 = regs[rd_addr2];
    end
  end

  // Debug port shows committed storage only, never the in-flight write.
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != 5'd0) begin
      dbg_data = regs[dbg_addr];
    end
  end

endmodule
